// File: rtl/jtag_pkg.sv
// jtag_pkg: channel constants and width helper shared by the JTAG DR bridge.
package jtag_pkg;
    localparam logic CH_ER1 = 1'b0;
    localparam logic CH_ER2 = 1'b1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/jtag_sync.sv
// jtag_sync: single-bit synchroniser chain for an asynchronous JTAG primitive output.
module jtag_sync #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic [DEPTH-1:0] chain;

    always_ff @(posedge clk or posedge reset)
        if (reset) chain <= '0;
        else chain <= {chain[DEPTH-2:0], d};

    assign q = chain[DEPTH-1];
endmodule

// File: rtl/jtag_dr_bridge.sv
// jtag_dr_bridge: moves ER1/ER2 user data registers from the TCK domain into clk
// with oversampled TCK, and hands completed updates out over valid/ready.
module jtag_dr_bridge
    import jtag_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    localparam int LW         = clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tck,
    input  logic             tdi,
    input  logic             test_logic_reset,
    input  logic             shift_dr_capture_dr,
    input  logic             update_dr,
    input  logic             enable_er1,
    input  logic             enable_er2,
    output logic             tdo_er1,
    output logic             tdo_er2,
    input  logic [WIDTH-1:0] cap_data_er1,
    input  logic [WIDTH-1:0] cap_data_er2,
    output logic [1:0]       cap_strobe,
    output logic [WIDTH-1:0] upd_data,
    output logic             upd_chan,
    output logic [LW-1:0]    upd_len,
    output logic             upd_valid,
    input  logic             upd_ready,
    output logic             overrun,
    input  logic             clr_overrun
);
    localparam logic [LW-1:0] FULL = LW'(WIDTH);

    logic [6:0] pins, syn;
    logic s_tck, s_tdi, s_tlr, s_sdc, s_upd, s_en1, s_en2;
    logic prev_tck, prev_upd, prev_sdc;
    logic tck_rise, update_rise, capture, shift, upd_go, go_chan;
    logic [1:0] sel;
    logic [WIDTH-1:0] cap [2];
    logic [WIDTH-1:0] sr [2];
    logic [LW-1:0] cnt [2];

    assign pins = {enable_er2, enable_er1, update_dr, shift_dr_capture_dr,
                   test_logic_reset, tdi, tck};

    for (genvar i = 0; i < 7; i++) begin : g_sync
        jtag_sync #(.DEPTH(SYNC_STAGES)) u_sync (
            .clk  (clk),
            .reset(reset),
            .d    (pins[i]),
            .q    (syn[i])
        );
    end

    assign {s_en2, s_en1, s_upd, s_sdc, s_tlr, s_tdi, s_tck} = syn;
    assign cap[CH_ER1] = cap_data_er1;
    assign cap[CH_ER2] = cap_data_er2;

    // Only a single selected channel acts; both-or-neither is treated as idle.
    assign sel         = {s_en2 & ~s_en1, s_en1 & ~s_en2};
    assign tck_rise    = s_tck & ~prev_tck;
    assign update_rise = s_upd & ~prev_upd;
    assign capture     = tck_rise & s_sdc & ~prev_sdc;
    assign shift       = tck_rise & s_sdc & prev_sdc;

    assign tdo_er1 = sr[CH_ER1][0];
    assign tdo_er2 = sr[CH_ER2][0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_tck   <= 1'b0;
            prev_upd   <= 1'b0;
            prev_sdc   <= 1'b0;
            cap_strobe <= '0;
            for (int c = 0; c < 2; c++) begin
                sr[c]  <= '0;
                cnt[c] <= '0;
            end
            upd_go    <= 1'b0;
            go_chan   <= 1'b0;
            upd_data  <= '0;
            upd_chan  <= 1'b0;
            upd_len   <= '0;
            upd_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            prev_tck   <= s_tck;
            prev_upd   <= s_upd;
            if (tck_rise) prev_sdc <= s_sdc;
            cap_strobe <= {2{capture & ~s_tlr}} & sel;
            for (int c = 0; c < 2; c++) begin
                if (s_tlr) begin
                    sr[c]  <= '0;
                    cnt[c] <= '0;
                end else if (capture && sel[c]) begin
                    sr[c]  <= cap[c];
                    cnt[c] <= '0;
                end else if (shift && sel[c]) begin
                    sr[c]  <= {s_tdi, sr[c][WIDTH-1:1]};
                    cnt[c] <= (cnt[c] == FULL) ? cnt[c] : cnt[c] + 1'b1;
                end
            end
            // Updates are staged one cycle so upd_valid lands SYNC_STAGES+2 after the pin edge.
            upd_go  <= update_rise & (s_en1 ^ s_en2);
            go_chan <= sel[CH_ER2];
            if (upd_go) begin
                upd_data <= sr[go_chan];
                upd_chan <= go_chan;
                upd_len  <= cnt[go_chan];
            end
            upd_valid <= upd_go | (upd_valid & ~upd_ready);
            overrun   <= (upd_go & upd_valid & ~upd_ready) | (overrun & ~clr_overrun);
        end
    end
endmodule

// File: tb/tb_jtag_dr_bridge.sv
// tb_jtag_dr_bridge: directed checks of capture, shift, update handshake, overrun,
// test-logic-reset and dual-enable behaviour of jtag_dr_bridge.
module tb_jtag_dr_bridge;
    localparam int W  = 32;
    localparam int LW = 6;

    logic clk = 1'b0;
    logic reset, tck, tdi, tlr, sdc, upd, en1, en2, upd_ready, clr_overrun;
    logic [W-1:0] cap1, cap2, upd_data;
    logic tdo1, tdo2, upd_chan, upd_valid, overrun;
    logic [1:0] cap_strobe;
    logic [LW-1:0] upd_len;
    logic [31:0] seq;
    int tests = 0, fails = 0, c1 = 0, c2 = 0, c1_snap, c2_snap;

    jtag_dr_bridge #(.WIDTH(W), .SYNC_STAGES(2)) dut (
        .clk                (clk),
        .reset              (reset),
        .tck                (tck),
        .tdi                (tdi),
        .test_logic_reset   (tlr),
        .shift_dr_capture_dr(sdc),
        .update_dr          (upd),
        .enable_er1         (en1),
        .enable_er2         (en2),
        .tdo_er1            (tdo1),
        .tdo_er2            (tdo2),
        .cap_data_er1       (cap1),
        .cap_data_er2       (cap2),
        .cap_strobe         (cap_strobe),
        .upd_data           (upd_data),
        .upd_chan           (upd_chan),
        .upd_len            (upd_len),
        .upd_valid          (upd_valid),
        .upd_ready          (upd_ready),
        .overrun            (overrun),
        .clr_overrun        (clr_overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cap_strobe[0]) c1++;
        if (cap_strobe[1]) c2++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tck_pulse(input logic d);
        tdi = d;
        clks(5);
        tck = 1'b1;
        clks(5);
        tck = 1'b0;
    endtask

    task automatic capture_dr();
        sdc = 1'b1;
        tck_pulse(1'b0);
    endtask

    task automatic exit_dr();
        sdc = 1'b0;
        tck_pulse(1'b0);
    endtask

    task automatic shift_bits(input logic ch, input logic [31:0] v, input int n, output logic [31:0] s);
        s = '0;
        for (int i = 0; i < n; i++) begin
            s[i] = ch ? tdo2 : tdo1;
            tck_pulse(v[i]);
        end
    endtask

    task automatic update_pulse();
        upd = 1'b1;
        clks(5);
        upd = 1'b0;
        clks(5);
    endtask

    task automatic ack();
        upd_ready = 1'b1;
        clks(1);
        upd_ready = 1'b0;
    endtask

    initial begin
        {tck, tdi, tlr, sdc, upd, en1, en2, upd_ready, clr_overrun} = '0;
        cap1  = 32'hA5A5_0F0F;
        cap2  = 32'hDEAD_BEEF;
        reset = 1'b1;
        clks(3);
        check("rst_valid", upd_valid, 0);
        check("rst_data", upd_data, 0);
        check("rst_len_chan", {upd_len, upd_chan}, 0);
        check("rst_tdo", {tdo1, tdo2}, 0);
        check("rst_ovr_strobe", {overrun, cap_strobe}, 0);
        reset = 1'b0;
        clks(2);

        // ER1 full 32-bit capture/shift/update with latency measurement
        en1 = 1'b1;
        capture_dr();
        check("er1_cap_strobe", {c2, c1}, {32'd0, 32'd1});
        shift_bits(1'b0, 32'h1234_5678, 32, seq);
        check("er1_tdo_seq", seq, 32'hA5A5_0F0F);
        exit_dr();
        upd = 1'b1;
        clks(3);
        check("lat_3", upd_valid, 0);
        clks(1);
        check("lat_4", upd_valid, 1);
        clks(3);
        upd = 1'b0;
        clks(5);
        check("er1_data", upd_data, 32'h1234_5678);
        check("er1_chan_len", {upd_chan, upd_len}, {1'b0, 6'd32});
        check("er1_valid_hold", upd_valid, 1);
        ack();
        check("er1_ack_drop", upd_valid, 0);

        // ER2 partial shift
        en1 = 1'b0;
        en2 = 1'b1;
        capture_dr();
        check("er2_cap_strobe", {c2, c1}, {32'd1, 32'd1});
        shift_bits(1'b1, 32'h0000_0ABC, 12, seq);
        check("er2_tdo_seq", seq[11:0], 12'hEEF);
        exit_dr();
        update_pulse();
        check("er2_data", upd_data, 32'hABCD_EADB);
        check("er2_chan_len", {upd_chan, upd_len}, {1'b1, 6'd12});
        ack();

        // two updates without ready -> overrun, then clear
        update_pulse();
        check("ovr_first", {upd_valid, upd_data}, {1'b1, 32'hABCD_EADB});
        en2  = 1'b0;
        en1  = 1'b1;
        cap1 = 32'h1111_1111;
        capture_dr();
        exit_dr();
        update_pulse();
        check("ovr_data", upd_data, 32'h1111_1111);
        check("ovr_chan_len", {upd_chan, upd_len}, 0);
        check("ovr_set", {upd_valid, overrun}, 2'b11);
        clr_overrun = 1'b1;
        clks(1);
        clr_overrun = 1'b0;
        check("ovr_clr", {upd_valid, overrun}, 2'b10);
        ack();

        // update coincident with ready handshake
        cap1 = 32'h2222_2222;
        capture_dr();
        exit_dr();
        update_pulse();
        cap1 = 32'h3333_3333;
        capture_dr();
        exit_dr();
        upd = 1'b1;
        clks(3);
        upd_ready = 1'b1;
        clks(1);
        upd_ready = 1'b0;
        check("coin_valid_ovr", {upd_valid, overrun}, 2'b10);
        check("coin_data", upd_data, 32'h3333_3333);
        clks(2);
        upd = 1'b0;
        clks(3);
        ack();
        check("coin_ack_drop", upd_valid, 0);

        // test_logic_reset mid-shift
        cap1 = 32'h4444_4444;
        capture_dr();
        shift_bits(1'b0, 32'h3, 2, seq);
        check("tlr_pre_tdo", tdo1, 1);
        tlr = 1'b1;
        clks(5);
        tlr = 1'b0;
        clks(3);
        check("tlr_tdo", tdo1, 0);
        check("tlr_keep_data", {upd_valid, upd_data}, {1'b0, 32'h3333_3333});
        exit_dr();
        update_pulse();
        check("tlr_upd", {upd_valid, upd_len, upd_data}, {1'b1, 6'd0, 32'h0});
        ack();

        // reset mid-shift
        cap1 = 32'h5555_5555;
        capture_dr();
        shift_bits(1'b0, 32'h7, 3, seq);
        reset = 1'b1;
        clks(2);
        check("rst_mid", {upd_valid, overrun, tdo1, upd_data}, 0);
        reset = 1'b0;
        clks(10);
        check("rst_mid_after", {upd_valid, tdo1}, 0);

        // both enables high: everything ignored
        sdc = 1'b0;
        en1 = 1'b1;
        en2 = 1'b1;
        c1_snap = c1;
        c2_snap = c2;
        capture_dr();
        shift_bits(1'b0, 32'hFFFF_FFFF, 32, seq);
        exit_dr();
        update_pulse();
        clks(5);
        check("both_strobe", {c1 - c1_snap, c2 - c2_snap}, 0);
        check("both_valid", upd_valid, 0);
        check("both_tdo", {tdo1, tdo2}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
